dmem_port: RTL and testbench

DMEM_PORT -- requirements
Module: dmem_port

---
 rtl/rv32i_types.sv | 27 ++
 rtl/dmem_align.sv | 50 +++++
 rtl/dmem_port.sv | 148 ++++++++++++++
 tb/tb_dmem_port.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Types and constants that the RV32I memory-stage port shares with the writeback stage.
package rv32i_types;

  typedef enum logic [2:0] {
    la_nothing = 3'd0,
    la_lw      = 3'd1,
    la_lhw_l   = 3'd2,
    la_lhw_u   = 3'd3,
    la_lb_l    = 3'd4,
    la_lb_ml   = 3'd5,
    la_lb_mu   = 3'd6,
    la_lb_u    = 3'd7
  } load_align_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FAULT = 2'd2
  } dport_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_align.sv
// Combinational lane decode: alignment check, byte-lane mask, store data replication
// and the writeback lane code for a load/store request.
module dmem_align
  import rv32i_types::*;
(
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic        misalign,
  output logic [3:0]  lane_mask,
  output logic [31:0] wdata_rep,
  output load_align_t load_align
);

  always_comb begin
    misalign   = 1'b0;
    lane_mask  = 4'b0000;
    wdata_rep  = wdata;
    load_align = la_nothing;
    case (funct3)
      F3_B, F3_BU: begin
        // Unsigned variants only exist for loads.
        misalign  = store && (funct3 == F3_BU);
        lane_mask = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        case (addr_lo)
          2'd0:    load_align = la_lb_l;
          2'd1:    load_align = la_lb_ml;
          2'd2:    load_align = la_lb_mu;
          default: load_align = la_lb_u;
        endcase
      end
      F3_H, F3_HU: begin
        misalign   = addr_lo[0] || (store && (funct3 == F3_HU));
        lane_mask  = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        load_align = addr_lo[1] ? la_lhw_u : la_lhw_l;
      end
      F3_W: begin
        misalign   = (addr_lo != 2'b00);
        lane_mask  = 4'b1111;
        load_align = la_lw;
      end
      default: misalign = 1'b1;
    endcase
    if (store) load_align = la_nothing;
  end

endmodule

// File: rtl/dmem_port.sv
// Memory-stage data port: captures one load/store, holds the dmem request stable
// until dmem_resp (or an optional timeout), and reports a one-cycle completion pulse.
module dmem_port
  import rv32i_types::*;
#(
  parameter int WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output load_align_t rsp_load_align,
  output logic        rsp_misalign,
  output logic        rsp_timeout,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_rmask,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata
);

  localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT_LAST = (WAIT_LIMIT > 0) ? CW'(WAIT_LIMIT - 1) : '0;

  dport_state_t state_q, state_d;
  logic [29:0]  addr_q, addr_d;
  logic         store_q, store_d;
  logic [3:0]   rmask_q, rmask_d;
  logic [3:0]   wmask_q, wmask_d;
  logic [31:0]  wdata_q, wdata_d;
  load_align_t  align_q, align_d;
  logic [CW-1:0] wait_q, wait_d;

  logic         a_misalign;
  logic [3:0]   a_mask;
  logic [31:0]  a_wdata;
  load_align_t  a_align;
  logic         timeout_hit;

  dmem_align u_align (
    .store      (req_store),
    .funct3     (req_funct3),
    .addr_lo    (req_addr[1:0]),
    .wdata      (req_wdata),
    .misalign   (a_misalign),
    .lane_mask  (a_mask),
    .wdata_rep  (a_wdata),
    .load_align (a_align)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= 1'b0;
      rmask_q <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
      align_q <= la_nothing;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      rmask_q <= rmask_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
      align_q <= align_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    store_d        = store_q;
    rmask_d        = rmask_q;
    wmask_d        = wmask_q;
    wdata_d        = wdata_q;
    align_d        = align_q;
    wait_d         = wait_q;
    stall          = 1'b0;
    rsp_valid      = 1'b0;
    rsp_rdata      = '0;
    rsp_load_align = la_nothing;
    rsp_misalign   = 1'b0;
    rsp_timeout    = 1'b0;
    timeout_hit    = (WAIT_LIMIT > 0) && (wait_q == LIMIT_LAST);
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          stall = 1'b1;
          if (a_misalign) begin
            state_d = FAULT;
          end else begin
            state_d = BUSY;
            addr_d  = req_addr[31:2];
            store_d = req_store;
            rmask_d = req_store ? 4'b0000 : a_mask;
            wmask_d = req_store ? a_mask : 4'b0000;
            wdata_d = a_wdata;
            align_d = a_align;
            wait_d  = '0;
          end
        end
      end
      BUSY: begin
        // A response arriving in the timeout cycle still counts as a normal completion.
        if (dmem_resp) begin
          rsp_valid      = 1'b1;
          rsp_rdata      = store_q ? 32'h0 : dmem_rdata;
          rsp_load_align = align_q;
          state_d        = IDLE;
        end else begin
          stall = 1'b1;
          if (timeout_hit) begin
            rsp_valid      = 1'b1;
            rsp_timeout    = 1'b1;
            rsp_load_align = align_q;
            state_d        = IDLE;
          end else if (WAIT_LIMIT > 0) begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      FAULT: begin
        rsp_valid    = 1'b1;
        rsp_misalign = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!rst_n) stall = 1'b0;
  end

  assign dmem_addr  = {addr_q, 2'b00};
  assign dmem_wdata = wdata_q;
  assign dmem_rmask = (state_q == BUSY) ? rmask_q : 4'b0000;
  assign dmem_wmask = (state_q == BUSY) ? wmask_q : 4'b0000;

endmodule

// File: tb/tb_dmem_port.sv
// Self-checking bench for dmem_port: vector table with a response scoreboard, plus
// directed sequences for reset, back-to-back accesses and ignored responses.
module tb_dmem_port;
  import rv32i_types::*;

  localparam int WL = 4;
  localparam int NO_RESP = 99;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  load_align_t rsp_load_align;
  logic        rsp_misalign;
  logic        rsp_timeout;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic        dmem_resp = 1'b0;
  logic [31:0] dmem_rdata = '0;

  always #5 clk = ~clk;

  dmem_port #(.WAIT_LIMIT(WL)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_store      (req_store),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .stall          (stall),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_load_align (rsp_load_align),
    .rsp_misalign   (rsp_misalign),
    .rsp_timeout    (rsp_timeout),
    .dmem_addr      (dmem_addr),
    .dmem_rmask     (dmem_rmask),
    .dmem_wmask     (dmem_wmask),
    .dmem_wdata     (dmem_wdata),
    .dmem_resp      (dmem_resp),
    .dmem_rdata     (dmem_rdata)
  );

  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] mem_rdata;
    logic        misalign;
    logic        timeout;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    load_align_t align;
    logic [31:0] rdata;
    int          stalls;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    load_align_t align;
    logic        misalign;
    logic        timeout;
  } rsp_t;

  rsp_t sb_q[$];
  vec_t vecs[0:17];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input int waits, input logic [31:0] mrd,
                              input logic mis, input logic to, input logic [3:0] rm,
                              input logic [3:0] wm, input logic [31:0] da, input logic [31:0] dwd,
                              input load_align_t al, input logic [31:0] rd, input int stalls);
    vec_t v;
    v.store = st;  v.f3 = f3;  v.addr = addr;  v.wdata = wd;  v.waits = waits;
    v.mem_rdata = mrd;  v.misalign = mis;  v.timeout = to;  v.rmask = rm;  v.wmask = wm;
    v.daddr = da;  v.dwdata = dwd;  v.align = al;  v.rdata = rd;  v.stalls = stalls;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    rsp_t e;
    int   stalls;
    bit   done;
    bit   first;
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_store  = v.store;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    dmem_resp  = 1'b0;
    dmem_rdata = v.mem_rdata;
    e.rdata = v.rdata;  e.align = v.align;  e.misalign = v.misalign;  e.timeout = v.timeout;
    sb_q.push_back(e);
    stalls = 0;
    done = 1'b0;
    first = 1'b1;
    @(negedge clk);
    if (stall) stalls++;
    check("accept_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 16 && !done; k++) begin
      dmem_resp = (k == v.waits);
      @(negedge clk);
      if (stall) stalls++;
      if (first) begin
        check("rmask", 32'(dmem_rmask), 32'(v.rmask));
        check("wmask", 32'(dmem_wmask), 32'(v.wmask));
        if (!v.misalign) check("dmem_addr", dmem_addr, v.daddr);
        if (!v.misalign && v.store) check("dmem_wdata", dmem_wdata, v.dwdata);
        first = 1'b0;
      end
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_rsp: got rsp_valid=1, want no pending request");
        end else begin
          e = sb_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_load_align", 32'(rsp_load_align), 32'(e.align));
          check("rsp_misalign", 32'(rsp_misalign), 32'(e.misalign));
          check("rsp_timeout", 32'(rsp_timeout), 32'(e.timeout));
        end
        done = 1'b1;
      end
      @(posedge clk); #1;
      dmem_resp = 1'b0;
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL rsp_wait: got no rsp_valid in 16 cycles, want one pulse (vec %0d)", idx);
      sb_q.delete();
    end
    check("stall_cycles", 32'(stalls), 32'(v.stalls));
    $display("vec %0d: store=%0b f3=%03b addr=0x%08h stalls=%0d", idx, v.store, v.f3, v.addr, stalls);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    vecs[0]  = mk(1, F3_B,   32'h1003, 32'hAABBCCDD, 0, 32'h12345678, 0, 0, 4'b0000, 4'b1000, 32'h1000, 32'hDDDDDDDD, la_nothing, 32'h0, 1);
    vecs[1]  = mk(0, F3_HU,  32'h2002, 32'h0, 3, 32'h80017FFF, 0, 0, 4'b1100, 4'b0000, 32'h2000, 32'h0, la_lhw_u, 32'h80017FFF, 4);
    vecs[2]  = mk(0, F3_W,   32'h3001, 32'h0, 0, 32'hDEADBEEF, 1, 0, 4'b0000, 4'b0000, 32'h0, 32'h0, la_nothing, 32'h0, 1);
    vecs[3]  = mk(0, F3_W,   32'h4000, 32'h0, NO_RESP, 32'h5555AAAA, 0, 1, 4'b1111, 4'b0000, 32'h4000, 32'h0, la_lw, 32'h0, 5);
    vecs[4]  = mk(1, F3_W,   32'h5004, 32'h11223344, 0, 32'h99999999, 0, 0, 4'b0000, 4'b1111, 32'h5004, 32'h11223344, la_nothing, 32'h0, 1);
    vecs[5]  = mk(0, F3_B,   32'h6001, 32'h0, 0, 32'hCAFEBABE, 0, 0, 4'b0010, 4'b0000, 32'h6000, 32'h0, la_lb_ml, 32'hCAFEBABE, 1);
    vecs[6]  = mk(1, F3_H,   32'h7002, 32'h0000BEEF, 1, 32'h0, 0, 0, 4'b0000, 4'b1100, 32'h7000, 32'hBEEFBEEF, la_nothing, 32'h0, 2);
    vecs[7]  = mk(0, F3_BU,  32'h8003, 32'h0, 2, 32'h01020304, 0, 0, 4'b1000, 4'b0000, 32'h8000, 32'h0, la_lb_u, 32'h01020304, 3);
    vecs[8]  = mk(0, F3_H,   32'h9000, 32'h0, 0, 32'h0000F00D, 0, 0, 4'b0011, 4'b0000, 32'h9000, 32'h0, la_lhw_l, 32'h0000F00D, 1);
    vecs[9]  = mk(1, F3_H,   32'h9001, 32'h1234, 0, 32'h0, 1, 0, 4'b0000, 4'b0000, 32'h0, 32'h0, la_nothing, 32'h0, 1);
    vecs[10] = mk(1, 3'b011, 32'hA000, 32'h1, 0, 32'h0, 1, 0, 4'b0000, 4'b0000, 32'h0, 32'h0, la_nothing, 32'h0, 1);
    vecs[11] = mk(0, 3'b110, 32'hA000, 32'h0, 0, 32'h0, 1, 0, 4'b0000, 4'b0000, 32'h0, 32'h0, la_nothing, 32'h0, 1);
    vecs[12] = mk(1, F3_BU,  32'hA000, 32'h5A, 0, 32'h0, 1, 0, 4'b0000, 4'b0000, 32'h0, 32'h0, la_nothing, 32'h0, 1);
    vecs[13] = mk(0, F3_W,   32'hB000, 32'h0, 3, 32'h76543210, 0, 0, 4'b1111, 4'b0000, 32'hB000, 32'h0, la_lw, 32'h76543210, 4);
    vecs[14] = mk(0, F3_B,   32'hC002, 32'h0, 0, 32'h11111111, 0, 0, 4'b0100, 4'b0000, 32'hC000, 32'h0, la_lb_mu, 32'h11111111, 1);
    vecs[15] = mk(0, F3_B,   32'hC000, 32'h0, 1, 32'h22222222, 0, 0, 4'b0001, 4'b0000, 32'hC000, 32'h0, la_lb_l, 32'h22222222, 2);
    vecs[16] = mk(0, F3_HU,  32'h2001, 32'h0, 0, 32'h0, 1, 0, 4'b0000, 4'b0000, 32'h0, 32'h0, la_nothing, 32'h0, 1);
    vecs[17] = mk(0, F3_W,   32'h3002, 32'h0, 0, 32'h0, 1, 0, 4'b0000, 4'b0000, 32'h0, 32'h0, la_nothing, 32'h0, 1);

    // Reset state, with a request and response already present on the inputs.
    req_valid = 1'b1;
    req_addr  = 32'h1234;
    dmem_resp = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rmask", 32'(dmem_rmask), 32'd0);
    check("reset_wmask", 32'(dmem_wmask), 32'd0);
    check("reset_dmem_addr", dmem_addr, 32'd0);
    check("reset_dmem_wdata", dmem_wdata, 32'd0);
    check("reset_load_align", 32'(rsp_load_align), 32'(la_nothing));
    $display("reset: outputs sampled with rst_n low");
    req_valid = 1'b0;
    dmem_resp = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

    // Back-to-back sw then lb with zero-wait memory; the early dmem_resp in IDLE must be ignored.
    @(posedge clk); #1;
    req_valid = 1'b1;  req_store = 1'b1;  req_funct3 = F3_W;  req_addr = 32'h100;  req_wdata = 32'h01020304;
    dmem_resp = 1'b1;  dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("b2b_idle_resp_ignored", 32'(rsp_valid), 32'd0);
    check("b2b_sw_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    req_store = 1'b0;  req_funct3 = F3_B;  req_addr = 32'h201;
    @(negedge clk);
    check("b2b_sw_rsp", 32'(rsp_valid), 32'd1);
    check("b2b_sw_wmask", 32'(dmem_wmask), 32'hF);
    check("b2b_sw_rdata", rsp_rdata, 32'd0);
    check("b2b_sw_stall_done", 32'(stall), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_gap_rsp", 32'(rsp_valid), 32'd0);
    check("b2b_lb_accept_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b_lb_rsp", 32'(rsp_valid), 32'd1);
    check("b2b_lb_rmask", 32'(dmem_rmask), 32'b0010);
    check("b2b_lb_rdata", rsp_rdata, 32'hFFFFFFFF);
    check("b2b_lb_align", 32'(rsp_load_align), 32'(la_lb_ml));
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    $display("seq b2b: sw 0x100 then lb 0x201");

    // Reset asserted in the middle of a BUSY wait abandons the access.
    req_valid = 1'b1;  req_store = 1'b0;  req_funct3 = F3_W;  req_addr = 32'hD000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_busy_rmask", 32'(dmem_rmask), 32'hF);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_busy_rmask_cleared", 32'(dmem_rmask), 32'd0);
    check("rst_busy_stall", 32'(stall), 32'd0);
    check("rst_busy_rsp", 32'(rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dmem_resp = 1'b1;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    check("rst_busy_no_rsp", 32'(pulses), 32'd0);
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    $display("seq reset_mid_busy: lw 0xD000 abandoned, pulses=%0d", pulses);

    run_vec(18, vecs[5]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
